// File: rtl/mod_multi.sv
// Sequential modular multiplier: R = (A * B) mod N.
// MSB-first interleaved shift-add-reduce. The running partial result P stays
// below N after every step, so one conditional subtract per step is enough
// and no double-width product register is needed.
module mod_multi #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] N,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] R
);

  typedef enum logic [1:0] {IDLE, DBL, ADD} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_reg, a_nxt;
  logic [WIDTH-1:0] b_sh, b_nxt;
  logic [WIDTH-1:0] n_reg, n_nxt;
  logic [WIDTH-1:0] p, p_nxt;
  logic [CNT_W-1:0] idx, idx_nxt;
  logic [WIDTH-1:0] r_reg, r_nxt;
  logic             done_reg, done_nxt;
  logic             err_reg, err_nxt;
  logic [WIDTH:0]   t;
  logic [WIDTH:0]   addend;

  // Reduce a WIDTH+1 bit intermediate modulo n, given it is below 2n.
  function automatic logic [WIDTH-1:0] cond_sub(input logic [WIDTH:0] v,
                                                input logic [WIDTH-1:0] n);
    logic [WIDTH:0] d;
    d = v - {1'b0, n};
    if (v >= {1'b0, n})
      return d[WIDTH-1:0];
    else
      return v[WIDTH-1:0];
  endfunction

  // Next-state and datapath: accept/validate, double step, conditional add step.
  always_comb begin
    state_nxt = state;
    a_nxt     = a_reg;
    b_nxt     = b_sh;
    n_nxt     = n_reg;
    p_nxt     = p;
    idx_nxt   = idx;
    r_nxt     = r_reg;
    done_nxt  = 1'b0;
    err_nxt   = err_reg;
    t         = '0;
    addend    = '0;
    case (state)
      IDLE: begin
        if (start) begin
          a_nxt = A;
          b_nxt = B;
          n_nxt = N;
          if ((N == '0) || (A >= N)) begin
            done_nxt = 1'b1;
            err_nxt  = 1'b1;
            r_nxt    = '0;
          end else begin
            p_nxt     = '0;
            idx_nxt   = CNT_W'(WIDTH - 1);
            err_nxt   = 1'b0;
            state_nxt = DBL;
          end
        end
      end
      DBL: begin
        t         = {p, 1'b0};
        p_nxt     = cond_sub(t, n_reg);
        state_nxt = ADD;
      end
      ADD: begin
        // b_sh is shifted left each ADD, so its MSB is the current bit B[i].
        if (b_sh[WIDTH-1])
          addend = {1'b0, a_reg};
        t     = {1'b0, p} + addend;
        p_nxt = cond_sub(t, n_reg);
        b_nxt = {b_sh[WIDTH-2:0], 1'b0};
        if (idx == '0) begin
          r_nxt     = p_nxt;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else begin
          idx_nxt   = idx - CNT_W'(1);
          state_nxt = DBL;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a_reg    <= '0;
      b_sh     <= '0;
      n_reg    <= '0;
      p        <= '0;
      idx      <= '0;
      r_reg    <= '0;
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
    end else begin
      state    <= state_nxt;
      a_reg    <= a_nxt;
      b_sh     <= b_nxt;
      n_reg    <= n_nxt;
      p        <= p_nxt;
      idx      <= idx_nxt;
      r_reg    <= r_nxt;
      done_reg <= done_nxt;
      err_reg  <= err_nxt;
    end
  end

  assign busy = (state != IDLE);
  assign done = done_reg;
  assign err  = err_reg;
  assign R    = r_reg;

endmodule

// File: tb/tb_mod_multi.sv
// Testbench for mod_multi: directed sequence with an expected-result queue.
module tb_mod_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a_in, b_in, n_in;
  logic       busy, done, err;
  logic [7:0] r_out;

  logic        start32;
  logic [31:0] a32, b32, n32;
  logic        busy32, done32, err32;
  logic [31:0] r32;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] r;
    logic       e;
    int         acc;
  } exp_t;

  exp_t q[$];

  mod_multi #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .A(a_in), .B(b_in), .N(n_in),
    .busy(busy), .done(done), .err(err), .R(r_out)
  );

  mod_multi #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .A(a32), .B(b32), .N(n32),
    .busy(busy32), .done(done32), .err(err32), .R(r32)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint unsigned mulmod(input longint unsigned a,
                                             input longint unsigned b,
                                             input longint unsigned n);
    return (a * b) % n;
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (q.size() == 0) begin
        check("unexpected_done", {63'd0, done}, 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("R", r_out, e.r);
        check("err", err, e.e);
        check("latency", cyc - e.acc, e.e ? 0 : 16);
      end
    end
  end

  task automatic push_exp(input logic [7:0] a, input logic [7:0] b, input logic [7:0] n);
    exp_t e;
    if (n == 0 || a >= n) begin
      e.r = 8'd0;
      e.e = 1'b1;
    end else begin
      e.r = 8'(mulmod(a, b, n));
      e.e = 1'b0;
    end
    e.acc = cyc;
    q.push_back(e);
  endtask

  // Drive one start pulse from the idle state; returns #1 after the accept edge.
  task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic [7:0] n);
    a_in  = a;
    b_in  = b;
    n_in  = n;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    push_exp(a, b, n);
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (q.size() != 0 && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    check(tag, q.size(), 0);
  endtask

  initial begin
    int bad;
    int k;
    int acc32;
    rst = 1'b1; start = 1'b0; a_in = 0; b_in = 0; n_in = 0;
    start32 = 1'b0; a32 = 0; b32 = 0; n32 = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_R", r_out, 0);
    check("rst_busy32", busy32, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic op with busy window and done timing
    launch(8'd5, 8'd7, 8'd11);
    bad = 0;
    for (int j = 0; j < 16; j++) begin
      if (busy !== 1'b1) bad++;
      @(posedge clk);
      #1;
    end
    check("busy_window", bad, 0);
    check("busy_end", busy, 0);
    check("done_at_2w", done, 1);
    wait_idle("to_basic");

    // Overflow-sensitive 8-bit case
    launch(8'd200, 8'd255, 8'd251);
    wait_idle("to_200");

    // 32-bit case exercising the WIDTH+1 bit intermediate
    a32 = 32'hFFFFFFFE; b32 = 32'hFFFFFFFE; n32 = 32'hFFFFFFFF;
    start32 = 1'b1;
    @(posedge clk);
    #1;
    start32 = 1'b0;
    acc32 = cyc;
    k = 0;
    while (done32 !== 1'b1 && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("done32", done32, 1);
    check("R32", r32, mulmod(64'hFFFFFFFE, 64'hFFFFFFFE, 64'hFFFFFFFF));
    check("err32", err32, 0);
    check("lat32", cyc - acc32, 64);

    // Illegal operands: N == 0, then A >= N
    launch(8'd5, 8'd7, 8'd0);
    check("e0_done", done, 1);
    check("e0_err", err, 1);
    check("e0_busy", busy, 0);
    check("e0_R", r_out, 0);
    bad = 0;
    for (int j = 0; j < 3; j++) begin
      @(posedge clk);
      #1;
      if (busy !== 1'b0) bad++;
    end
    check("e0_nobusy", bad, 0);
    check("e0_err_sticky", err, 1);
    check("e0_done_pulse", done, 0);
    launch(8'd12, 8'd7, 8'd11);
    check("e1_done", done, 1);
    check("e1_err", err, 1);
    check("e1_busy", busy, 0);
    @(posedge clk);
    #1;
    launch(8'd3, 8'd4, 8'd11);
    check("err_cleared", err, 0);
    wait_idle("to_legal_after_err");

    // Start while busy is ignored; input changes mid-op have no effect
    launch(8'd5, 8'd7, 8'd11);
    repeat (4) @(posedge clk);
    #1;
    a_in = 8'd1; b_in = 8'd1; n_in = 8'd3; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a_in = 8'hAA; b_in = 8'h55; n_in = 8'h07;
    wait_idle("to_ignore");

    // Back-to-back with start held high
    a_in = 8'd6; b_in = 8'd9; n_in = 8'd13; start = 1'b1;
    @(posedge clk);
    #1;
    push_exp(8'd6, 8'd9, 8'd13);
    for (int j = 0; j < 2; j++) begin
      repeat (17) @(posedge clk);
      #1;
      push_exp(8'd6, 8'd9, 8'd13);
    end
    start = 1'b0;
    wait_idle("to_b2b");

    // Reset mid-operation aborts without done
    launch(8'd5, 8'd7, 8'd11);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_R", r_out, 0);
    repeat (20) @(posedge clk);
    #1;
    launch(8'd200, 8'd255, 8'd251);
    wait_idle("to_after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
